// File: rtl/ucie_ctl_phy_pkg.sv
// Shared types and constants for the UCIe PHY-side control/data blocks.
package ucie_ctl_phy_pkg;

   typedef enum logic [1:0] {
      RESET  = 2'd0,
      READY  = 2'd1,
      ACTIVE = 2'd2,
      DRAIN  = 2'd3
   } data_xfer_buf_states_e;

   localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hF2;

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is read combinationally from storage.
module ucie_ctl_sync_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [DW-1:0]              i_data,
   input  logic                       i_pop,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [DW-1:0]              o_head,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_q, wr_d;
   logic [AW:0]   rd_q, rd_d;
   logic          pop_ok;

   assign o_empty = (wr_q == rd_q);
   assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign o_level = wr_q - rd_q;
   assign o_head  = o_empty ? '0 : mem_q[rd_q[AW-1:0]];
   assign pop_ok  = i_pop && !o_empty;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (i_flush) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (i_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
         if (pop_ok) rd_d = rd_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage carries no reset; validity is tracked purely by the pointers.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) mem_q[wr_q[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/ucie_ctl_phy_data_xfer_buf.sv
// PHY data-transfer engine: registered TX pipe with error injection, buffered RX path with drain.
module ucie_ctl_phy_data_xfer_buf
   import ucie_ctl_phy_pkg::*;
#(
   parameter int         NBYTES        = 4,
   parameter int         RX_DEPTH      = 4,
   parameter logic [7:0] ERR_BYTE      = ERR_BYTE_DEFAULT,
   parameter bit         ERR_ALL_LANES = 1'b0,
   parameter int         CNT_W         = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic                  i_rdi_lp_irdy,
   input  logic                  i_rdi_lp_valid,
   input  logic [NBYTES*8-1:0]   i_rdi_lp_data,
   input  logic [NBYTES*8-1:0]   i_data_received,
   input  logic                  i_data_valid,
   input  logic                  i_phy_req_data_error,
   input  logic                  i_phy_stall,
   output logic                  o_rdi_pl_trdy,
   output logic                  o_rdi_pl_valid,
   output logic [NBYTES*8-1:0]   o_rdi_pl_data,
   output logic [NBYTES*8-1:0]   o_data_sent,
   output logic                  o_data_valid,
   output logic                  o_rx_overflow,
   output logic [CNT_W-1:0]      o_tx_count,
   output logic [CNT_W-1:0]      o_rx_count
);

   localparam int DW = NBYTES * 8;
   localparam int AW = $clog2(RX_DEPTH);

   function automatic logic [DW-1:0] err_mask();
      logic [DW-1:0] m;
      m = '0;
      for (int b = 0; b < NBYTES; b++) begin
         if (ERR_ALL_LANES || b == 0) m[b*8 +: 8] = ERR_BYTE;
      end
      return m;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   data_xfer_buf_states_e state_q, state_d;

   logic          en_st;
   logic          tx_hs;
   logic          rx_valid, rx_pop, rx_push_req, rx_push, rx_drop;
   logic          fifo_full, fifo_empty, fifo_empty_next;
   logic [DW-1:0] fifo_head;
   logic [AW:0]   fifo_level;
   logic          enter_reset;

   logic          tx_vld_q, tx_vld_d;
   logic [DW-1:0] tx_data_q, tx_data_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic          ovf_q, ovf_d;

   assign en_st           = (state_q == READY) || (state_q == ACTIVE);
   assign o_rdi_pl_trdy   = en_st && !i_phy_stall;
   assign tx_hs           = i_rdi_lp_valid && o_rdi_pl_trdy;

   assign rx_valid        = !fifo_empty && (state_q != RESET);
   assign rx_pop          = rx_valid && i_rdi_lp_irdy;
   assign rx_push_req     = i_data_valid && en_st;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign rx_push         = rx_push_req && (!fifo_full || rx_pop);
   assign rx_drop         = rx_push_req && fifo_full && !rx_pop;
   assign fifo_empty_next = fifo_empty || (rx_pop && fifo_level == {{AW{1'b0}}, 1'b1});

   always_comb begin
      state_d = state_q;
      case (state_q)
         RESET:  if (i_enable) state_d = READY;
         READY,
         ACTIVE: begin
            if (!i_enable)                      state_d = fifo_empty ? RESET : DRAIN;
            else if (tx_hs)                     state_d = ACTIVE;
            else                                state_d = READY;
         end
         DRAIN: begin
            if (i_enable)                       state_d = READY;
            else if (fifo_empty_next)           state_d = RESET;
         end
         default:                               state_d = RESET;
      endcase
   end

   assign enter_reset = (state_q != RESET) && (state_d == RESET);

   always_comb begin
      tx_vld_d  = tx_hs;
      tx_data_d = '0;
      if (tx_hs) tx_data_d = i_rdi_lp_data ^ (i_phy_req_data_error ? err_mask() : '0);

      tx_cnt_d = tx_cnt_q;
      rx_cnt_d = rx_cnt_q;
      ovf_d    = ovf_q;
      if (enter_reset) begin
         tx_cnt_d = '0;
         rx_cnt_d = '0;
         ovf_d    = 1'b0;
      end else begin
         if (tx_hs)   tx_cnt_d = sat_inc(tx_cnt_q);
         if (rx_push) rx_cnt_d = sat_inc(rx_cnt_q);
         if (rx_drop) ovf_d    = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= RESET;
         tx_vld_q  <= 1'b0;
         tx_data_q <= '0;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_vld_q  <= tx_vld_d;
         tx_data_q <= tx_data_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   ucie_ctl_sync_fifo #(
      .DW    (DW),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (enter_reset),
      .i_push  (rx_push),
      .i_data  (i_data_received),
      .i_pop   (rx_pop),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_head  (fifo_head),
      .o_level (fifo_level)
   );

   assign o_rdi_pl_valid = rx_valid;
   assign o_rdi_pl_data  = rx_valid ? fifo_head : '0;
   assign o_data_valid   = tx_vld_q;
   assign o_data_sent    = tx_data_q;
   assign o_rx_overflow  = ovf_q;
   assign o_tx_count     = tx_cnt_q;
   assign o_rx_count     = rx_cnt_q;

endmodule
